// File: rtl/fmac_pkg.sv
// Shared types and constants for the fmac operand feeder and its FIFO.
package fmac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ZERO = 2'd2
    } feeder_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] x;
        logic [DATA_W_DEF-1:0] y;
    } operand_pair_t;

endpackage

// File: rtl/fmac_pair_fifo.sv
// Synchronous FIFO of operand pairs; level comes from extra-bit pointer difference.
module fmac_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so push alongside pop is legal when full.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fmac_operand_feeder.sv
// Feeds buffered (x, y) pairs to fmac, each followed by a (0,0) cycle, with frame pulses.
// Optional FMAC_FEEDER_STATS_EN adds a 16-bit wrapping pair_count output.
module fmac_operand_feeder
    import fmac_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   run,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_x,
    input  logic [DATA_W-1:0]      in_y,
    output logic [DATA_W-1:0]      x,
    output logic [DATA_W-1:0]      y,
    output logic                   emit,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] level,
    output feeder_state_t          dbg_state
`ifdef FMAC_FEEDER_STATS_EN
    ,
    output logic [15:0]            pair_count
`endif
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    feeder_state_t     state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
    logic              emit_q, emit_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic                  fifo_full, fifo_empty, pop;
    logic [2*DATA_W-1:0]   fifo_rdata;

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready.
    assign in_ready = !fifo_full;

    fmac_pair_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .wdata ({in_x, in_y}),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pops only from IDLE or ZERO, which guarantees a zero cycle after every pair.
    assign pop = run && !fifo_empty && (state_q != EMIT);

    always_comb begin
        state_d      = state_q;
        x_d          = '0;
        y_d          = '0;
        emit_d       = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            EMIT: begin
                state_d = ZERO;
                if (frame_cnt_q == CNT_W'(FRAME_LEN-1)) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = '0;
                end else begin
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end
            end
            default: begin
                if (pop) begin
                    state_d = EMIT;
                    x_d     = fifo_rdata[2*DATA_W-1:DATA_W];
                    y_d     = fifo_rdata[DATA_W-1:0];
                    emit_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            emit_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            emit_q       <= emit_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign emit       = emit_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

`ifdef FMAC_FEEDER_STATS_EN
    logic [15:0] pair_count_q, pair_count_d;

    always_comb begin
        pair_count_d = pair_count_q;
        if (pop) begin
            pair_count_d = pair_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pair_count_q <= '0;
        end else begin
            pair_count_q <= pair_count_d;
        end
    end

    assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_fmac_operand_feeder.sv
// Directed bench for fmac_operand_feeder (DATA_W=8, DEPTH=8, FRAME_LEN=4).
module tb_fmac_operand_feeder;
    import fmac_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       run = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic [7:0] x, y;
    logic       emit, frame_done;
    logic [3:0] level;
    feeder_state_t dbg_state;
`ifdef FMAC_FEEDER_STATS_EN
    logic [15:0] pair_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    fmac_operand_feeder #(.DATA_W(8), .DEPTH(8), .FRAME_LEN(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .run        (run),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .x          (x),
        .y          (y),
        .emit       (emit),
        .frame_done (frame_done),
        .level      (level),
        .dbg_state  (dbg_state)
`ifdef FMAC_FEEDER_STATS_EN
        ,
        .pair_count (pair_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        run = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    task automatic push_pair(input logic [7:0] px, input logic [7:0] py);
        in_valid = 1'b1;
        in_x = px;
        in_y = py;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        run = 1'b0;
        in_valid = 1'b1;
        in_x = 8'h11;
        in_y = 8'h22;
        tick();
        tick();
        tests_run++;
        if ({emit, frame_done, x, y} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: emit=%0b fd=%0b x=%0d y=%0d, want all 0", emit, frame_done, x, y);
        end
        tests_run++;
        if (in_ready !== 1'b1 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_ready_level: in_ready=%0b level=%0d, want 1/0", in_ready, level);
        end
        in_valid = 1'b0;
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) push_pair(8'(i + 1), 8'(i + 5));
        tests_run++;
        if (level !== 4'd3) begin
            tests_failed++;
            $display("FAIL idle_level: got %0d want 3", level);
        end
        tests_run++;
        if ({emit, x, y} !== 17'd0 || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL idle_no_emit: emit=%0b x=%0d y=%0d state=%0d, want 0/0/0/IDLE", emit, x, y, dbg_state);
        end
    endtask

    task automatic test_basic_stream();
        logic [7:0] px [4] = '{8'd3, 8'd3, 8'd5, 8'd1};
        logic [7:0] py [4] = '{8'd4, 8'd4, 8'd6, 8'd1};
        logic       ee [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        logic [7:0] ex [10] = '{0, 3, 0, 3, 0, 5, 0, 1, 0, 0};
        logic [7:0] ey [10] = '{0, 4, 0, 4, 0, 6, 0, 1, 0, 0};
        logic       ef [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [3:0] el [10] = '{1, 1, 2, 2, 2, 1, 1, 0, 0, 0};
        apply_reset();
        run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin
                in_x = px[c];
                in_y = py[c];
            end
            tick();
            tests_run++;
            if ({emit, x, y, frame_done, level} !== {ee[c], ex[c], ey[c], ef[c], el[c]}) begin
                tests_failed++;
                $display("FAIL stream_c%0d: emit=%0b x=%0d y=%0d fd=%0b lvl=%0d, want %0b %0d %0d %0b %0d",
                         c, emit, x, y, frame_done, level, ee[c], ex[c], ey[c], ef[c], el[c]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_pair();
        logic [7:0] px [4] = '{8'd0, 8'd7, 8'd0, 8'd2};
        logic [7:0] py [4] = '{8'd0, 8'd1, 8'd0, 8'd2};
        apply_reset();
        for (int i = 0; i < 4; i++) push_pair(px[i], py[i]);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({emit, x, y} !== {1'b1, px[i], py[i]}) begin
                tests_failed++;
                $display("FAIL zero_pair_emit%0d: emit=%0b x=%0d y=%0d, want 1 %0d %0d", i, emit, x, y, px[i], py[i]);
            end
            tick();
            tests_run++;
            if ({emit, x, y, frame_done} !== {17'd0, (i == 3)}) begin
                tests_failed++;
                $display("FAIL zero_pair_gap%0d: emit=%0b x=%0d y=%0d fd=%0b, want 0 0 0 %0b", i, emit, x, y, frame_done, (i == 3));
            end
        end
        run = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] ex, ey;
        apply_reset();
        for (int i = 0; i < 8; i++) push_pair(8'(i + 1), 8'(i + 17));
        tests_run++;
        if (level !== 4'd8 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_flags: level=%0d in_ready=%0b, want 8/0", level, in_ready);
        end
        push_pair(8'hAA, 8'hBB);
        tests_run++;
        if (level !== 4'd8) begin
            tests_failed++;
            $display("FAIL full_drop: level=%0d want 8", level);
        end
        run = 1'b1;
        in_valid = 1'b1;
        in_x = 8'h99;
        in_y = 8'h98;
        tick();
        tests_run++;
        if ({emit, x, y} !== {1'b1, 8'd1, 8'd17} || level !== 4'd7) begin
            tests_failed++;
            $display("FAIL full_first_pop: emit=%0b x=%0d y=%0d lvl=%0d, want 1 1 17 7", emit, x, y, level);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (level !== 4'd8 || emit !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_refill: level=%0d emit=%0b, want 8/0", level, emit);
        end
        for (int i = 1; i < 9; i++) begin
            ex = (i < 8) ? 8'(i + 1) : 8'h99;
            ey = (i < 8) ? 8'(i + 17) : 8'h98;
            tick();
            tests_run++;
            if ({emit, x, y} !== {1'b1, ex, ey}) begin
                tests_failed++;
                $display("FAIL full_order%0d: emit=%0b x=%0h y=%0h, want 1 %0h %0h", i, emit, x, y, ex, ey);
            end
            tick();
        end
        tests_run++;
        if (level !== 4'd0 || emit !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drained: level=%0d emit=%0b, want 0/0", level, emit);
        end
        run = 1'b0;
    endtask

    task automatic test_run_toggle();
        apply_reset();
        push_pair(8'd10, 8'd11);
        push_pair(8'd20, 8'd21);
        push_pair(8'd30, 8'd31);
        run = 1'b1;
        tick();
        tests_run++;
        if ({emit, x, y} !== {1'b1, 8'd10, 8'd11} || dbg_state !== EMIT) begin
            tests_failed++;
            $display("FAIL toggle_a: emit=%0b x=%0d y=%0d st=%0d, want 1 10 11 EMIT", emit, x, y, dbg_state);
        end
        run = 1'b0;
        tick();
        tests_run++;
        if ({emit, x, y} !== 17'd0 || dbg_state !== ZERO) begin
            tests_failed++;
            $display("FAIL toggle_zero: emit=%0b x=%0d y=%0d st=%0d, want 0 0 0 ZERO", emit, x, y, dbg_state);
        end
        tick();
        tick();
        tests_run++;
        if ({emit, x, y} !== 17'd0 || dbg_state !== IDLE || level !== 4'd2) begin
            tests_failed++;
            $display("FAIL toggle_idle: emit=%0b x=%0d st=%0d lvl=%0d, want 0 0 IDLE 2", emit, x, dbg_state, level);
        end
        run = 1'b1;
        tick();
        tests_run++;
        if ({emit, x, y} !== {1'b1, 8'd20, 8'd21}) begin
            tests_failed++;
            $display("FAIL toggle_b: emit=%0b x=%0d y=%0d, want 1 20 21", emit, x, y);
        end
        tick();
        tick();
        tests_run++;
        if ({emit, x, y} !== {1'b1, 8'd30, 8'd31} || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL toggle_c: emit=%0b x=%0d y=%0d lvl=%0d, want 1 30 31 0", emit, x, y, level);
        end
        tick();
        tick();
        tests_run++;
        if (dbg_state !== IDLE || emit !== 1'b0) begin
            tests_failed++;
            $display("FAIL toggle_end: st=%0d emit=%0b, want IDLE 0", dbg_state, emit);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        for (int i = 0; i < 5; i++) push_pair(8'(i + 40), 8'(i + 50));
        run = 1'b1;
        repeat (4) tick();
        tests_run++;
        if (level !== 4'd3 || dbg_state !== ZERO) begin
            tests_failed++;
            $display("FAIL mid_pre: level=%0d st=%0d, want 3 ZERO", level, dbg_state);
        end
        tick();
        RESET = 1'b0;
        #1;
        tests_run++;
        if ({emit, x, y, frame_done} !== 18'd0 || level !== 4'd0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL mid_reset: emit=%0b x=%0d y=%0d lvl=%0d rdy=%0b st=%0d, want 0 0 0 0 1 IDLE",
                     emit, x, y, level, in_ready, dbg_state);
        end
        run = 1'b0;
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(8'(i + 60), 8'(i + 70));
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({emit, x, y} !== {1'b1, 8'(i + 60), 8'(i + 70)}) begin
                tests_failed++;
                $display("FAIL mid_emit%0d: emit=%0b x=%0d y=%0d, want 1 %0d %0d", i, emit, x, y, i + 60, i + 70);
            end
            tick();
            tests_run++;
            if (frame_done !== (i == 3)) begin
                tests_failed++;
                $display("FAIL mid_frame%0d: frame_done=%0b want %0b", i, frame_done, (i == 3));
            end
        end
        run = 1'b0;
    endtask

`ifdef FMAC_FEEDER_STATS_EN
    task automatic test_stats();
        apply_reset();
        tests_run++;
        if (pair_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: pair_count=%0d want 0", pair_count);
        end
        for (int i = 0; i < 5; i++) push_pair(8'(i + 1), 8'(i + 2));
        run = 1'b1;
        repeat (12) tick();
        tests_run++;
        if (pair_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL stats_count: pair_count=%0d want 5", pair_count);
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_stream();
        test_zero_pair();
        test_full();
        test_run_toggle();
        test_reset_mid_frame();
`ifdef FMAC_FEEDER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
